// File: rtl/neander_muldiv_unit.sv
// neander_muldiv_unit
//
// Sequential radix-2 multiply/divide engine for the NEANDER-X datapath.
// MUL uses shift-add and DIV/MOD use restoring division. Each takes WIDTH
// RUN cycles. Divide-by-zero skips RUN and completes on the next cycle.
//
// Optional feature macro: NEANDER_MULDIV_SIGNED_EN
//   When defined, op_signed=1 makes the unit treat operands as two's
//   complement. Magnitudes are taken when the operands are latched, the
//   core runs unsigned, and signs are fixed up as the results load in DONE.
//   When undefined, op_signed is ignored and no sign logic is built.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             request; accepted in IDLE or DONE only
//   op                00=MUL 01=DIV 10=MOD 11=MUL
//   op_signed         two's complement operands (signed build only)
//   a, b              multiplicand/dividend, multiplier/divisor
//   busy              high exactly while in RUN
//   done              one-cycle pulse, results valid
//   result_lo/hi      MUL: product lo/hi; DIV: quo/rem; MOD: rem/quo
//   div_by_zero       last DIV/MOD had b==0; cleared by next accepted start
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start
// RUN    | one radix-2 step per cycle, WIDTH cycles
// DONE   | results loaded, done pulse; may accept a new start

module neander_muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_MOD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // MUL: product high half; DIV: partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;       // MUL: multiplier/product low; DIV: dividend/quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;   // MUL: multiplicand; DIV: divisor
    logic             div_q, div_d;
    logic             mod_q, mod_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             in_div;

`ifdef NEANDER_MULDIV_SIGNED_EN
    logic neg_a, neg_b;
    logic neg_main_q, neg_main_d;   // negate product / quotient
    logic neg_rem_q, neg_rem_d;     // negate remainder (follows dividend)

    always_comb begin
        neg_a = op_signed & a[WIDTH-1];
        neg_b = op_signed & b[WIDTH-1];
        mag_a = neg_a ? (~a + 1'b1) : a;
        mag_b = neg_b ? (~b + 1'b1) : b;
    end
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
    assign mag_a = a;
    assign mag_b = b;
`endif

    assign in_div = (op == OP_DIV) || (op == OP_MOD);

    // One radix-2 step of the active algorithm.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] step_acc, step_mq;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, mq_q[WIDTH-1]};
        // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (div_q) begin
            step_acc = div_ge ? div_sub : div_shift[WIDTH-1:0];
            step_mq  = {mq_q[WIDTH-2:0], div_ge};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
    end

    // Final results from the last step, with sign correction when enabled.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef NEANDER_MULDIV_SIGNED_EN
    always_comb begin
        prod_fix = neg_main_q ? (~{step_acc, step_mq} + 1'b1) : {step_acc, step_mq};
        quo_fix  = neg_main_q ? (~step_mq + 1'b1) : step_mq;
        rem_fix  = neg_rem_q ? (~step_acc + 1'b1) : step_acc;
    end
`else
    assign prod_fix = {step_acc, step_mq};
    assign quo_fix  = step_mq;
    assign rem_fix  = step_acc;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        mod_d   = mod_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dbz_d   = dbz_q;
`ifdef NEANDER_MULDIV_SIGNED_EN
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
`endif
        case (state_q)
            S_RUN: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    if (!div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (mod_q) begin
                        lo_d = rem_fix;
                        hi_d = quo_fix;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                if (start) begin
                    dbz_d = 1'b0;
                    div_d = in_div;
                    mod_d = (op == OP_MOD);
                    if (in_div && (b == '0)) begin
                        // Quotient all ones, remainder is the raw dividend.
                        state_d = S_DONE;
                        dbz_d   = 1'b1;
                        lo_d    = (op == OP_MOD) ? a : '1;
                        hi_d    = (op == OP_MOD) ? '1 : a;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = '0;
                        opnd_d  = in_div ? mag_b : mag_a;
                        mq_d    = in_div ? mag_a : mag_b;
`ifdef NEANDER_MULDIV_SIGNED_EN
                        neg_main_d = neg_a ^ neg_b;
                        neg_rem_d  = neg_a;
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            mod_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            dbz_q   <= 1'b0;
`ifdef NEANDER_MULDIV_SIGNED_EN
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            mod_q   <= mod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dbz_q   <= dbz_d;
`ifdef NEANDER_MULDIV_SIGNED_EN
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_neander_muldiv_unit.sv
module tb_neander_muldiv_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic         op_signed;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_lo, result_hi;

    neander_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op_signed(op_signed),
        .a(a), .b(b), .busy(busy), .done(done), .result_lo(result_lo),
        .result_hi(result_hi), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [1:0]   op;
        logic         sgn;
        logic [W-1:0] a, b, lo, hi;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] lo, hi;
        logic         dz;
        int           start_edge;
        int           lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(string name, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (edge %0d)", name, got, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            exp_t r;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got=1 expected=0 (edge %0d)", cyc);
            end else begin
                r = sb.pop_front();
                check("result_lo", 32'(result_lo), 32'(r.lo));
                check("result_hi", 32'(result_hi), 32'(r.hi));
                check("div_by_zero", 32'(div_by_zero), 32'(r.dz));
                check("latency", 32'(cyc - r.start_edge), 32'(r.lat));
            end
        end
    end

    task automatic add_vec(logic [1:0] o, logic s, logic [W-1:0] av, logic [W-1:0] bv,
                           logic [W-1:0] lo, logic [W-1:0] hi, logic dz);
        vec_t v;
        v.op = o; v.sgn = s; v.a = av; v.b = bv; v.lo = lo; v.hi = hi; v.dz = dz;
        vecs.push_back(v);
    endtask

    task automatic push_exp(logic [W-1:0] lo, logic [W-1:0] hi, logic dz);
        exp_t r;
        r.lo = lo; r.hi = hi; r.dz = dz;
        r.start_edge = cyc + 1;
        r.lat = dz ? 0 : W;
        sb.push_back(r);
    endtask

    task automatic start_op(logic [1:0] o, logic s, logic [W-1:0] av, logic [W-1:0] bv,
                            logic [W-1:0] lo, logic [W-1:0] hi, logic dz);
        @(negedge clk);
        op = o; op_signed = s; a = av; b = bv; start = 1'b1;
        push_exp(lo, hi, dz);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int d0, b0, n;
        logic [W-1:0] last_lo;

        add_vec(2'b00, 1'b0, 16'd300,  16'd500,  16'h49F0, 16'h0002, 1'b0);
        add_vec(2'b01, 1'b0, 16'd1000, 16'd7,    16'd142,  16'd6,    1'b0);
        add_vec(2'b10, 1'b0, 16'd1000, 16'd7,    16'd6,    16'd142,  1'b0);
        add_vec(2'b01, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);
        add_vec(2'b10, 1'b0, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);
        add_vec(2'b00, 1'b0, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        add_vec(2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0);
        add_vec(2'b01, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
        add_vec(2'b01, 1'b0, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0);
        add_vec(2'b10, 1'b0, 16'h8000, 16'h0003, 16'h0002, 16'h2AAA, 1'b0);
        add_vec(2'b11, 1'b0, 16'd12,   16'd13,   16'd156,  16'h0000, 1'b0);
        add_vec(2'b01, 1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0);
        add_vec(2'b01, 1'b1, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1);
`ifdef NEANDER_MULDIV_SIGNED_EN
        add_vec(2'b01, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
        add_vec(2'b00, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0);
        add_vec(2'b01, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
        add_vec(2'b10, 1'b1, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0);
        add_vec(2'b10, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0);
`else
        add_vec(2'b01, 1'b1, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0);
        add_vec(2'b00, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'h0004, 1'b0);
        add_vec(2'b01, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
        add_vec(2'b10, 1'b1, 16'h0007, 16'hFFFE, 16'h0007, 16'h0000, 1'b0);
        add_vec(2'b10, 1'b1, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0);
`endif

        reset = 1'b1; start = 1'b0; op = 2'b00; op_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lo", 32'(result_lo), 32'd0);
        check("rst_hi", 32'(result_hi), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        last_lo = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
                     vecs[i].lo, vecs[i].hi, vecs[i].dz);
            wait_idle();
            last_lo = vecs[i].lo;
        end

        // MUL with a stray start pulse during RUN; results must not move until DONE.
        d0 = done_cnt; b0 = busy_cnt;
        start_op(2'b00, 1'b0, 16'd300, 16'd500, 16'h49F0, 16'h0002, 1'b0);
        repeat (5) @(negedge clk);
        check("hold_during_run", 32'(result_lo), 32'(last_lo));
        op = 2'b01; a = 16'd1; b = 16'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("busy_cycles", 32'(busy_cnt - b0), 32'(W));

        // Back-to-back: start held high through DONE, operands disturbed mid-run.
        d0 = done_cnt;
        @(negedge clk);
        op = 2'b01; op_signed = 1'b0; a = 16'd1000; b = 16'd7; start = 1'b1;
        push_exp(16'd142, 16'd6, 1'b0);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 3) a = 16'hDEAD;
            if (done) break;
        end
        if (done) begin
            op = 2'b00; a = 16'h1234; b = 16'h0010;
            push_exp(16'h2340, 16'h0001, 1'b0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle();
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

        // Divide-by-zero flag holds, then clears on the next accepted start.
        start_op(2'b01, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("dbz_hold", 32'(div_by_zero), 32'd1);
        start_op(2'b00, 1'b0, 16'd2, 16'd3, 16'd6, 16'd0, 1'b0);
        @(negedge clk);
        check("dbz_clear", 32'(div_by_zero), 32'd0);
        wait_idle();

        // Reset mid-DIV aborts with no done, outputs cleared.
        start_op(2'b01, 1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_lo", 32'(result_lo), 32'd0);
        check("abort_hi", 32'(result_hi), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        d0 = done_cnt;
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        start_op(2'b00, 1'b0, 16'd300, 16'd500, 16'h49F0, 16'h0002, 1'b0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
